// File: rtl/aes_pkg.sv
// AES shared definitions: block width, S-box, Rcon, GF(2^8) helpers, key-size mapping, FSM states.
// Latency: n/a (constants and combinational functions only).
// Backpressure: n/a.
// Contents: NB, aes_fsm_e {IDLE,RUN,DONE}, sbox(), sub_word(), rot_word(), rcon(), xtime(), nr_for_nk().
package aes_pkg;

   // Columns per state (32-bit words per 128-bit block).
   localparam int NB = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } aes_fsm_e;

   // Forward S-box, entry 0 in the most significant byte.
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Round constants, index 0 (unused) in the most significant byte, up to index 10.
   localparam logic [87:0] RCON_TABLE = 88'h00_01_02_04_08_10_20_40_80_1b_36;

   // Entry b sits at byte position 255-b from the bottom, i.e. ~b.
   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TABLE[{~b, 3'b000} +: 8];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [7:0] rcon(input int i);
      return RCON_TABLE[8*(10-i) +: 8];
   endfunction

   // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic int nr_for_nk(input int nk);
      return nk + 6;
   endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One AES encryption round: SubBytes, ShiftRows, MixColumns (skipped when final), AddRoundKey.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; caller decides when to register the result.
// Ports: state_in[127:0] (byte 0 in MSB), round_key[127:0], is_final -> state_out[127:0].
module aes_enc_round
   import aes_pkg::*;
(
   input  logic [127:0] state_in,
   input  logic [127:0] round_key,
   input  logic         is_final,
   output logic [127:0] state_out
);

   // Element 0 maps to bits [127:120], matching the external byte order.
   logic [0:15][7:0] in_b;
   logic [0:15][7:0] sb_b;
   logic [0:15][7:0] sr_b;
   logic [0:15][7:0] mc_b;

   assign in_b = state_in;

   always_comb begin
      logic [7:0] a0, a1, a2, a3;
      sb_b = '0;
      sr_b = '0;
      mc_b = '0;
      a0   = '0;
      a1   = '0;
      a2   = '0;
      a3   = '0;

      for (int n = 0; n < 16; n++) begin
         sb_b[n] = sbox(in_b[n]);
      end

      // Byte 4c+r is row r of column c; row r rotates left by r columns.
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            sr_b[4*c+r] = sb_b[4*((c+r)%4)+r];
         end
      end

      for (int c = 0; c < 4; c++) begin
         a0 = sr_b[4*c];
         a1 = sr_b[4*c+1];
         a2 = sr_b[4*c+2];
         a3 = sr_b[4*c+3];
         mc_b[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         mc_b[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         mc_b[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         mc_b[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
   end

   assign state_out = (is_final ? sr_b : mc_b) ^ round_key;

endmodule

// File: rtl/aes_key_expand.sv
// AES key schedule: expands an NK-word cipher key into NR+1 128-bit round keys.
// Latency: 0 cycles, purely combinational from the key input.
// Backpressure: none.
// Ports: key[32*NK-1:0] (byte 0 in MSB) -> round_keys[NR:0][127:0], round_keys[i] = words 4i..4i+3.
module aes_key_expand
   import aes_pkg::*;
#(
   parameter  int NK = 4,
   localparam int NR = nr_for_nk(NK)
) (
   input  logic [32*NK-1:0]      key,
   output logic [NR:0][127:0]    round_keys
);

   localparam int NW = NB * (NR + 1);

   logic [31:0] w [NW];

   // Written in index order in one process so each word sees its predecessors.
   always_comb begin
      logic [31:0] temp;
      temp       = '0;
      round_keys = '0;
      for (int i = 0; i < NW; i++) begin
         if (i < NK) begin
            w[i] = key[32*(NK-1-i) +: 32];
         end else begin
            temp = w[i-1];
            if (i % NK == 0) begin
               temp = sub_word(rot_word(temp)) ^ {rcon(i / NK), 24'h000000};
            end else if (NK > 6 && i % NK == 4) begin
               // AES-256 adds an extra SubWord halfway through each key-length group.
               temp = sub_word(temp);
            end
            w[i] = w[i-NK] ^ temp;
         end
      end
      for (int r = 0; r <= NR; r++) begin
         round_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      end
   end

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES encryption, one round per clock; key size fixed by NK (4/6/8 words).
// Latency: out_valid rises NR edges after the accepting edge; NR+1 cycles per block back-to-back.
// Backpressure: result held in DONE until out_ready; in_ready follows out_ready there, low during RUN.
// Ports: clk, rst (sync, active high); in_valid/in_ready with plaintext[127:0], key[32*NK-1:0];
//        out_valid/out_ready with ciphertext[127:0]; all byte 0 in MSB.
module aes_cipher_iter
   import aes_pkg::*;
#(
   parameter  int NK = 4,
   localparam int NR = nr_for_nk(NK)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [127:0]        plaintext,
   input  logic [32*NK-1:0]    key,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [127:0]        ciphertext
);

   if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
      $error("aes_cipher_iter: NK must be 4, 6 or 8");
   end

   aes_fsm_e           fsm_q, fsm_d;
   logic [3:0]         rnd_q, rnd_d;
   logic [127:0]       st_q, st_d;
   logic [32*NK-1:0]   key_q, key_d;
   logic [127:0]       ct_q, ct_d;

   logic [NR:0][127:0] round_keys;
   logic [127:0]       rk_cur;
   logic [127:0]       round_out;
   logic               is_final;

   // Schedule runs off the latched key only, so the key input may change once accepted.
   aes_key_expand #(
      .NK (NK)
   ) u_key_expand (
      .key        (key_q),
      .round_keys (round_keys)
   );

   assign rk_cur   = round_keys[rnd_q];
   assign is_final = (rnd_q == 4'(NR));

   aes_enc_round u_round (
      .state_in  (st_q),
      .round_key (rk_cur),
      .is_final  (is_final),
      .state_out (round_out)
   );

   always_comb begin
      fsm_d     = fsm_q;
      rnd_d     = rnd_q;
      st_d      = st_q;
      key_d     = key_q;
      ct_d      = ct_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;

      case (fsm_q)
         IDLE: begin
            in_ready = 1'b1;
         end
         RUN: begin
            st_d = round_out;
            if (is_final) begin
               ct_d  = round_out;
               fsm_d = DONE;
            end else begin
               rnd_d = rnd_q + 4'd1;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            // Retiring and accepting in one cycle keeps the core busy back-to-back.
            in_ready  = out_ready;
            if (out_ready) begin
               fsm_d = IDLE;
            end
         end
         default: begin
            fsm_d = IDLE;
         end
      endcase

      // Round key 0 is the first four key words, so the live key can be used directly.
      if (in_valid && in_ready) begin
         key_d = key;
         st_d  = plaintext ^ key[32*NK-1 -: 128];
         rnd_d = 4'd1;
         fsm_d = RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q <= IDLE;
         rnd_q <= '0;
         st_q  <= '0;
         key_q <= '0;
         ct_q  <= '0;
      end else begin
         fsm_q <= fsm_d;
         rnd_q <= rnd_d;
         st_q  <= st_d;
         key_q <= key_d;
         ct_q  <= ct_d;
      end
   end

   // Separate result register: stable through DONE, kept in IDLE and while the next block runs.
   assign ciphertext = ct_q;

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Bench for aes_cipher_iter: one instance per key size, directed known-answer vectors plus
// handshake sequences (backpressure, back-to-back, reset mid-run).
module tb_aes_cipher_iter;

   logic         clk;
   logic         rst;
   logic         out_ready;
   logic [127:0] pt_r;
   logic [255:0] key_r;
   logic         iv [3];
   logic         ir [3];
   logic         ov [3];
   logic [127:0] ct [3];

   int checks;
   int failures;

   aes_cipher_iter #(.NK(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
      .plaintext(pt_r), .key(key_r[255:128]),
      .out_valid(ov[0]), .out_ready(out_ready), .ciphertext(ct[0])
   );

   aes_cipher_iter #(.NK(6)) dut6 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
      .plaintext(pt_r), .key(key_r[255:64]),
      .out_valid(ov[1]), .out_ready(out_ready), .ciphertext(ct[1])
   );

   aes_cipher_iter #(.NK(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
      .plaintext(pt_r), .key(key_r),
      .out_valid(ov[2]), .out_ready(out_ready), .ciphertext(ct[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int           nk;
      logic [127:0] pt;
      logic [255:0] key;
      logic [127:0] ct;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Counts edges until out_valid of instance idx rises; gives up after 40.
   task automatic wait_ov(input int idx, output int n);
      n = 0;
      while (!ov[idx] && n < 40) begin
         tick();
         n++;
      end
   endtask

   task automatic accept(input int idx, input logic [127:0] p, input logic [255:0] k);
      pt_r    = p;
      key_r   = k;
      iv[idx] = 1'b1;
      tick();
      iv[idx] = 1'b0;
      // Scramble the inputs: the running block must not see them.
      pt_r    = ~p;
      key_r   = ~k;
   endtask

   initial begin
      int n;
      int idx;
      string tag;

      checks    = 0;
      failures  = 0;
      out_ready = 1'b0;
      pt_r      = '0;
      key_r     = '0;
      for (int i = 0; i < 3; i++) iv[i] = 1'b0;

      vecs[0] = '{4, 128'h00112233445566778899aabbccddeeff,
                  {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a};
      vecs[1] = '{6, 128'h00112233445566778899aabbccddeeff,
                  {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                  128'hdda97ca4864cdfe06eaf70a0ec0d7191};
      vecs[2] = '{8, 128'h00112233445566778899aabbccddeeff,
                  256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                  128'h8ea2b7ca516745bfeafc49904b496089};
      vecs[3] = '{4, 128'h3243f6a8885a308d313198a2e0370734,
                  {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                  128'h3925841d02dc09fbdc118597196a0b32};
      vecs[4] = '{4, 128'h0, 256'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
      vecs[5] = '{6, 128'h0, 256'h0, 128'haae06992acbf52a3e8f4a96ec9300bd7};
      vecs[6] = '{8, 128'h0, 256'h0, 128'hdc95c078a2408989ad48a21492842087};

      // Reset state of every instance.
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("reset_in_ready%0d", i), {127'b0, ir[i]}, 128'd1);
         chk($sformatf("reset_out_valid%0d", i), {127'b0, ov[i]}, 128'd0);
         chk($sformatf("reset_ct%0d", i), ct[i], 128'h0);
      end

      // Known-answer vectors with latency check and key/plaintext scrambled during RUN.
      for (int v = 0; v < 7; v++) begin
         idx = (vecs[v].nk - 4) / 2;
         out_ready = 1'b0;
         accept(idx, vecs[v].pt, vecs[v].key);
         wait_ov(idx, n);
         chk($sformatf("vec%0d_latency", v), 128'(n), 128'(vecs[v].nk + 6));
         chk($sformatf("vec%0d_ct", v), ct[idx], vecs[v].ct);
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
         chk($sformatf("vec%0d_retire", v), {127'b0, ov[idx]}, 128'd0);
         chk($sformatf("vec%0d_idle_hold", v), ct[idx], vecs[v].ct);
      end

      // Backpressure: result held for 5 cycles with out_ready low, in_valid high throughout.
      accept(0, vecs[0].pt, vecs[0].key);
      iv[0] = 1'b1;
      wait_ov(0, n);
      chk("bp_latency", 128'(n), 128'd10);
      for (int c = 0; c < 5; c++) begin
         tag = $sformatf("bp_cycle%0d", c);
         chk({tag, "_vld_rdy"}, {126'b0, ov[0], ir[0]}, 128'b10);
         chk({tag, "_ct"}, ct[0], vecs[0].ct);
         tick();
      end
      iv[0] = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("bp_retire", {127'b0, ov[0]}, 128'd0);

      // Back-to-back: second block accepted on the retiring edge of the first.
      accept(0, vecs[0].pt, vecs[0].key);
      wait_ov(0, n);
      chk("b2b_first_ct", ct[0], vecs[0].ct);
      pt_r      = vecs[3].pt;
      key_r     = vecs[3].key;
      iv[0]     = 1'b1;
      out_ready = 1'b1;
      #1;
      chk("b2b_in_ready_in_done", {127'b0, ir[0]}, 128'd1);
      tick();
      // Keep in_valid high with junk during RUN: it must be ignored.
      pt_r      = ~vecs[3].pt;
      key_r     = ~vecs[3].key;
      out_ready = 1'b0;
      chk("b2b_running", {126'b0, ov[0], ir[0]}, 128'b00);
      wait_ov(0, n);
      chk("b2b_second_gap", 128'(n + 1), 128'd11);
      chk("b2b_second_ct", ct[0], vecs[3].ct);
      iv[0]     = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // Reset during round 5 aborts, then a fresh block completes.
      accept(0, vecs[3].pt, vecs[3].key);
      for (int c = 0; c < 4; c++) tick();
      chk("mid_busy", {127'b0, ir[0]}, 128'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_in_ready", {127'b0, ir[0]}, 128'd1);
      chk("mid_rst_out_valid", {127'b0, ov[0]}, 128'd0);
      chk("mid_rst_ct", ct[0], 128'h0);
      accept(0, vecs[4].pt, vecs[4].key);
      wait_ov(0, n);
      chk("mid_after_latency", 128'(n), 128'd10);
      chk("mid_after_ct", ct[0], vecs[4].ct);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
